// File: rtl/sfif_ca_pkg.sv
// Shared constants for the SFIF credit-aware arbiter: channel indices, shadow
// counter widths and the DW-per-data-credit ratio.
package sfif_ca_pkg;
  localparam int CH_P          = 0;
  localparam int CH_NP         = 1;
  localparam int CH_CPL        = 2;
  localparam int HDR_CNT_W     = 8;
  localparam int DAT_CNT_W     = 12;
  localparam int DW_PER_CREDIT = 4;
endpackage

// File: rtl/sfif_ca_chan.sv
// One credit channel: shadow of the core header/data credits, data-credit need
// for the pending TLP, credit eligibility, and load/charge of the shadow.
module sfif_ca_chan
  import sfif_ca_pkg::*;
#(
  parameter int LEN_W      = 10,
  parameter int HDR_MARGIN = 1,
  parameter int DAT_MARGIN = 0
) (
  input  logic                 clk_125,
  input  logic                 rstn,
  input  logic [HDR_CNT_W:0]   i_ca_hdr,
  input  logic [DAT_CNT_W:0]   i_ca_dat,
  input  logic                 i_upd,
  input  logic [LEN_W-1:0]     i_req_len,
  input  logic                 i_charge,
  output logic                 o_credit_ok
);
  logic                 r_hdr_inf, r_dat_inf;
  logic [HDR_CNT_W-1:0] r_hdr_cnt;
  logic [DAT_CNT_W-1:0] r_dat_cnt;

  logic [LEN_W:0]       w_len_rnd;
  logic [LEN_W-2:0]     w_need_n;
  logic [DAT_CNT_W-1:0] w_need_d;
  logic [DAT_CNT_W:0]   w_dat_req;
  logic                 w_len_zero, w_hdr_ok, w_dat_ok;

  logic                 w_hdr_inf_nxt, w_dat_inf_nxt;
  logic [HDR_CNT_W-1:0] w_hdr_base, w_hdr_cnt_nxt;
  logic [DAT_CNT_W-1:0] w_dat_base, w_dat_cnt_nxt;

  // Round the DW length up to whole 16-byte credits.
  assign w_len_rnd  = {1'b0, i_req_len} + (LEN_W+1)'(DW_PER_CREDIT - 1);
  assign w_need_n   = w_len_rnd[LEN_W:2];
  assign w_need_d   = DAT_CNT_W'(w_need_n);
  assign w_dat_req  = {1'b0, w_need_d} + (DAT_CNT_W+1)'(DAT_MARGIN);
  assign w_len_zero = (i_req_len == '0);

  assign w_hdr_ok    = r_hdr_inf | (r_hdr_cnt >= HDR_CNT_W'(1 + HDR_MARGIN));
  assign w_dat_ok    = r_dat_inf | w_len_zero | ({1'b0, r_dat_cnt} >= w_dat_req);
  assign o_credit_ok = w_hdr_ok & w_dat_ok;

  // A fresh core snapshot does not yet include a grant on the same edge,
  // so the charge is applied on top of the loaded value.
  always_comb begin
    w_hdr_inf_nxt = i_upd ? i_ca_hdr[HDR_CNT_W]     : r_hdr_inf;
    w_hdr_base    = i_upd ? i_ca_hdr[HDR_CNT_W-1:0] : r_hdr_cnt;
    w_dat_inf_nxt = i_upd ? i_ca_dat[DAT_CNT_W]     : r_dat_inf;
    w_dat_base    = i_upd ? i_ca_dat[DAT_CNT_W-1:0] : r_dat_cnt;
    w_hdr_cnt_nxt = w_hdr_base;
    w_dat_cnt_nxt = w_dat_base;
    if (i_charge && !w_hdr_inf_nxt)
      w_hdr_cnt_nxt = (w_hdr_base == '0) ? '0 : w_hdr_base - HDR_CNT_W'(1);
    if (i_charge && !w_dat_inf_nxt && !w_len_zero)
      w_dat_cnt_nxt = (w_dat_base < w_need_d) ? '0 : w_dat_base - w_need_d;
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      r_hdr_inf <= 1'b0;
      r_dat_inf <= 1'b0;
      r_hdr_cnt <= '0;
      r_dat_cnt <= '0;
    end else begin
      r_hdr_inf <= w_hdr_inf_nxt;
      r_dat_inf <= w_dat_inf_nxt;
      r_hdr_cnt <= w_hdr_cnt_nxt;
      r_dat_cnt <= w_dat_cnt_nxt;
    end
  end
endmodule

// File: rtl/sfif_ca_arb.sv
// Credit-aware round-robin arbiter between SFIF TLP sources and the PCIe TX core.
// Build option SFIF_CA_STATS_EN adds per-channel 16-bit credit-stall counters.
module sfif_ca_arb
  import sfif_ca_pkg::*;
#(
  parameter int LEN_W      = 10,
  parameter int HDR_MARGIN = 1,
  parameter int DAT_MARGIN = 0,
  parameter int NCH        = 3
) (
  input  logic                 clk_125,
  input  logic                 rstn,
  input  logic [8:0]           ca_ph,
  input  logic [8:0]           ca_nph,
  input  logic [8:0]           ca_cplh,
  input  logic [12:0]          ca_pd,
  input  logic [12:0]          ca_npd,
  input  logic [12:0]          ca_cpld,
  input  logic                 ca_upd,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH*LEN_W-1:0] req_len,
  output logic [NCH-1:0]       gnt,
  output logic [NCH-1:0]       ch_avail,
`ifdef SFIF_CA_STATS_EN
  output logic [NCH*16-1:0]    stall_cnt,
`endif
  output logic                 credit_available
);
  // Handshake: a source raises req_valid[c] with a stable req_len slice and
  // holds both until gnt[c] pulses for one cycle; on the following cycle it
  // either drops req_valid[c] or presents its next TLP.
  localparam int PTR_W = $clog2(NCH);

  logic [HDR_CNT_W:0] w_ca_hdr [3];
  logic [DAT_CNT_W:0] w_ca_dat [3];
  logic [NCH-1:0]     w_credit_ok, w_elig, w_win;
  logic [NCH-1:0]     r_gnt, r_ch_avail;
  logic               r_credit_available, w_found;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt, w_idx;
  logic [PTR_W:0]     w_sum;

  assign w_ca_hdr[CH_P]   = ca_ph;
  assign w_ca_hdr[CH_NP]  = ca_nph;
  assign w_ca_hdr[CH_CPL] = ca_cplh;
  assign w_ca_dat[CH_P]   = ca_pd;
  assign w_ca_dat[CH_NP]  = ca_npd;
  assign w_ca_dat[CH_CPL] = ca_cpld;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    sfif_ca_chan #(
      .LEN_W(LEN_W), .HDR_MARGIN(HDR_MARGIN), .DAT_MARGIN(DAT_MARGIN)
    ) u_chan (
      .clk_125     (clk_125),
      .rstn        (rstn),
      .i_ca_hdr    (w_ca_hdr[c]),
      .i_ca_dat    (w_ca_dat[c]),
      .i_upd       (ca_upd),
      .i_req_len   (req_len[c*LEN_W +: LEN_W]),
      .i_charge    (w_win[c]),
      .o_credit_ok (w_credit_ok[c])
    );
`ifdef SFIF_CA_STATS_EN
    logic [15:0] r_stall;
    always_ff @(posedge clk_125 or negedge rstn) begin
      if (!rstn)
        r_stall <= '0;
      else if (req_valid[c] && !w_credit_ok[c] && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
    end
    assign stall_cnt[c*16 +: 16] = r_stall;
`endif
  end

  // Masking with the current grant stops a still-held request being granted twice.
  assign w_elig = req_valid & ~r_gnt & w_credit_ok;

  always_comb begin
    w_win     = '0;
    w_found   = 1'b0;
    w_ptr_nxt = r_ptr;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < NCH; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NCH))
        w_sum = w_sum - (PTR_W+1)'(NCH);
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && w_elig[w_idx]) begin
        w_found      = 1'b1;
        w_win[w_idx] = 1'b1;
        w_ptr_nxt    = (w_idx == PTR_W'(NCH - 1)) ? '0 : w_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      r_gnt              <= '0;
      r_ch_avail         <= '0;
      r_credit_available <= 1'b0;
      r_ptr              <= '0;
    end else begin
      r_gnt              <= w_win;
      r_ch_avail         <= req_valid & w_credit_ok;
      r_credit_available <= |(req_valid & w_credit_ok);
      r_ptr              <= w_ptr_nxt;
    end
  end

  assign gnt              = r_gnt;
  assign ch_avail         = r_ch_avail;
  assign credit_available = r_credit_available;
endmodule

// File: tb/tb_sfif_ca_arb.sv
// Directed bench for sfif_ca_arb: expected grants go into a queue, a negedge
// monitor pops and compares every grant the arbiter issues.
module tb_sfif_ca_arb;
  localparam int NCH   = 3;
  localparam int LEN_W = 10;

  logic                 clk_125 = 1'b0;
  logic                 rstn;
  logic [8:0]           ca_ph, ca_nph, ca_cplh;
  logic [12:0]          ca_pd, ca_npd, ca_cpld;
  logic                 ca_upd;
  logic [NCH-1:0]       req_valid;
  logic [NCH*LEN_W-1:0] req_len;
  logic [NCH-1:0]       gnt, ch_avail;
  logic                 credit_available;
`ifdef SFIF_CA_STATS_EN
  logic [NCH*16-1:0]    stall_cnt;
`endif

  int             n_checks = 0;
  int             n_errors = 0;
  logic [NCH-1:0] exp_q[$];
  logic [NCH-1:0] mon_exp;
  int             n_seen;

  sfif_ca_arb #(.LEN_W(LEN_W), .HDR_MARGIN(1), .DAT_MARGIN(0), .NCH(NCH)) dut (
    .clk_125          (clk_125),
    .rstn             (rstn),
    .ca_ph            (ca_ph),
    .ca_nph           (ca_nph),
    .ca_cplh          (ca_cplh),
    .ca_pd            (ca_pd),
    .ca_npd           (ca_npd),
    .ca_cpld          (ca_cpld),
    .ca_upd           (ca_upd),
    .req_valid        (req_valid),
    .req_len          (req_len),
    .gnt              (gnt),
    .ch_avail         (ch_avail),
`ifdef SFIF_CA_STATS_EN
    .stall_cnt        (stall_cnt),
`endif
    .credit_available (credit_available)
  );

  // Clock and watchdog
  always #4 clk_125 = ~clk_125;

  initial begin
    #5000000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk_125) begin
    if (rstn === 1'b1 && gnt !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_gnt", 32'(gnt), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("gnt_order", 32'(gnt), 32'(mon_exp));
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk_125);
    #1;
  endtask

  task automatic set_ca(input logic [8:0] ph, input logic [12:0] pd,
                        input logic [8:0] nph, input logic [12:0] npd,
                        input logic [8:0] cplh, input logic [12:0] cpld);
    ca_ph = ph; ca_pd = pd; ca_nph = nph; ca_npd = npd; ca_cplh = cplh; ca_cpld = cpld;
  endtask

  task automatic pulse_upd();
    ca_upd = 1'b1;
    tick(1);
    ca_upd = 1'b0;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    req_len   = '0;
    ca_upd    = 1'b0;
    set_ca(9'd0, 13'd0, 9'd0, 13'd0, 9'd0, 13'd0);
    tick(2);
    rstn = 1'b1;
    tick(1);
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_len   = '0;
    ca_upd    = 1'b0;
    set_ca(9'd0, 13'd0, 9'd0, 13'd0, 9'd0, 13'd0);
    tick(2);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ch_avail", 32'(ch_avail), 32'd0);
    check("rst_credit_available", 32'(credit_available), 32'd0);
    rstn = 1'b1;
    tick(1);

    // No credits loaded yet: a held P request must never be granted.
    req_len[0 +: LEN_W] = 10'd16;
    req_valid = 3'b001;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("no_upd_gnt", 32'(gnt), 32'd0);
      check("no_upd_credit_available", 32'(credit_available), 32'd0);
    end

    // ph=3, pd=8, len 16 (4 credits): two grants, spaced two cycles apart.
    set_ca(9'd3, 13'd8, 9'd0, 13'd0, 9'd0, 13'd0);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b001);
    pulse_upd();
    check("p_gnt_e0", 32'(gnt), 32'd0);
    tick(1);
    check("p_gnt_e1", 32'(gnt), 32'b001);
    tick(1);
    check("p_gnt_e2", 32'(gnt), 32'd0);
    tick(1);
    check("p_gnt_e3", 32'(gnt), 32'b001);
    tick(10);
    check("p_exhausted_ch_avail", 32'(ch_avail[0]), 32'd0);
    check("p_exhausted_credit_available", 32'(credit_available), 32'd0);
    check("p_two_grants_drained", 32'(exp_q.size()), 32'd0);
    req_valid = '0;

    // All credits infinite, all three channels requesting: round robin.
    do_reset();
    req_len   = {10'd16, 10'd16, 10'd16};
    req_valid = 3'b111;
    set_ca(9'h100, 13'h1000, 9'h100, 13'h1000, 9'h100, 13'h1000);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    pulse_upd();
    n_seen = 0;
    for (int i = 0; i < 12 && n_seen < 4; i++) begin
      tick(1);
      if (gnt != '0) n_seen++;
      if (n_seen == 4) req_valid = '0;
    end
    check("rr_grant_count", 32'(n_seen), 32'd4);
    tick(4);
    check("rr_drained", 32'(exp_q.size()), 32'd0);
    check("rr_idle_credit_available", 32'(credit_available), 32'd0);

    // ca_upd nph=4 on the same edge as an NP grant: shadow becomes 3, so
    // exactly two more grants follow (3->2, 2->1) for three in total.
    do_reset();
    req_len[LEN_W +: LEN_W] = 10'd0;
    req_valid = 3'b010;
    set_ca(9'd0, 13'd0, 9'd2, 13'd0, 9'd0, 13'd0);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b010);
    pulse_upd();
    ca_nph = 9'd4;
    pulse_upd();
    check("np_upd_gnt_same_edge", 32'(gnt), 32'b010);
    tick(12);
    check("np_exhausted_ch_avail", 32'(ch_avail[1]), 32'd0);
    check("np_three_grants", 32'(exp_q.size()), 32'd0);
    req_valid = '0;

    // len 5 needs 2 data credits: pd=1 blocks, pd=2 grants one cycle after the load.
    do_reset();
    req_len[0 +: LEN_W] = 10'd5;
    req_valid = 3'b001;
    set_ca(9'd3, 13'd1, 9'd0, 13'd0, 9'd0, 13'd0);
    pulse_upd();
    tick(5);
    check("len5_pd1_ch_avail", 32'(ch_avail[0]), 32'd0);
    check("len5_pd1_credit_available", 32'(credit_available), 32'd0);
    exp_q.push_back(3'b001);
    ca_pd = 13'd2;
    pulse_upd();
    check("len5_gnt_at_load", 32'(gnt), 32'd0);
    tick(1);
    check("len5_gnt_latency", 32'(gnt), 32'b001);
    check("len5_ch_avail", 32'(ch_avail[0]), 32'd1);
    check("len5_credit_available", 32'(credit_available), 32'd1);
    req_valid = '0;
    tick(1);
    check("len5_after_ch_avail", 32'(ch_avail[0]), 32'd0);
    check("len5_drained", 32'(exp_q.size()), 32'd0);

    // Reset while a grant is on the wire, then no grant until the next ca_upd.
    do_reset();
    req_len[0 +: LEN_W] = 10'd16;
    req_valid = 3'b001;
    set_ca(9'h100, 13'h1000, 9'd0, 13'd0, 9'd0, 13'd0);
    pulse_upd();
    tick(1);
    check("midrst_gnt_before", 32'(gnt), 32'b001);
    rstn = 1'b0;
    #1;
    check("midrst_gnt_cleared", 32'(gnt), 32'd0);
    check("midrst_ch_avail_cleared", 32'(ch_avail), 32'd0);
    check("midrst_credit_available_cleared", 32'(credit_available), 32'd0);
    #2;
    rstn = 1'b1;
    tick(8);
    check("midrst_no_credit", 32'(credit_available), 32'd0);
    exp_q.push_back(3'b001);
    pulse_upd();
    tick(1);
    check("midrst_regrant", 32'(gnt), 32'b001);
    req_valid = '0;
    tick(3);

`ifdef SFIF_CA_STATS_EN
    // Credit-blocked P request saturates its stall counter.
    do_reset();
    req_len[0 +: LEN_W] = 10'd16;
    req_valid = 3'b001;
    tick(70000);
    check("stall_p_saturated", 32'(stall_cnt[15:0]), 32'hFFFF);
    check("stall_np_idle", 32'(stall_cnt[31:16]), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("stall_async_clear", 32'(stall_cnt[15:0]), 32'd0);
    req_valid = '0;
    tick(1);
    rstn = 1'b1;
    tick(1);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
